// File: rtl/montgomery_top.sv
// -----------------------------------------------------------------------------
// montgomery_top
// Fully pipelined Montgomery multiplier for the Kyber modulus q = 3329 with
// radix R = 2^12.  It computes r = a*b*R^-1 mod q, fully reduced.  One operand
// pair can be accepted per clock, and results return in issue order exactly
// four clocks after the sampling edge.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   en     in   operand valid; a/b are sampled on every edge where en=1
//   a      in   [11:0] multiplicand, expected in [0, Q-1]
//   b      in   [11:0] multiplier,   expected in [0, Q-1]
//   busy   out  high while any accepted operation is still in flight
//   done   out  one-cycle result strobe, one per accepted operation
//   r      out  [11:0] result a*b*2^-12 mod Q
// -----------------------------------------------------------------------------
module montgomery_top #(
    parameter logic [11:0] Q      = 12'd3329,
    parameter logic [11:0] QPRIME = 12'd3327   // -Q^-1 mod 2^12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        busy,
    output logic        done,
    output logic [11:0] r
);

    // Register layers between the sampling edge and the result:
    // operand capture, product T, (T, m), u, reduced r.
    localparam int LAT = 4;

    // Stage-valid shift register; bit LAT is the result-valid strobe.
    logic [LAT:0] r_vld;
    logic         r_busy;

    // Operand capture
    logic [11:0]  r_a;
    logic [11:0]  r_b;
    // S1: full product
    logic [23:0]  r_t1;
    // S2: product carried forward plus REDC quotient m
    logic [23:0]  r_t2;
    logic [11:0]  r_m2;
    // S3: u = (T + m*Q) >> 12, always < 2Q for in-range operands
    logic [12:0]  r_u3;
    // S4: fully reduced result
    logic [11:0]  r_res;

    logic [23:0]  w_prod;
    logic [23:0]  w_mprod;
    logic [11:0]  w_m;
    logic [23:0]  w_mq;
    logic [24:0]  w_sum;
    logic [12:0]  w_u;
    logic [13:0]  w_diff;
    logic [11:0]  w_res;

    assign w_prod  = {12'd0, r_a} * {12'd0, r_b};

    // Only the low 12 bits of T matter for m, and m is taken mod 2^12.
    assign w_mprod = {12'd0, r_t1[11:0]} * {12'd0, QPRIME};
    assign w_m     = w_mprod[11:0];

    // m was chosen so that T + m*Q is divisible by 2^12; the low bits of the
    // sum are zero and are simply dropped.
    assign w_mq    = {12'd0, r_m2} * {12'd0, Q};
    assign w_sum   = {1'b0, r_t2} + {1'b0, w_mq};
    assign w_u     = w_sum[24:12];

    // Single conditional subtraction; a borrow (bit 13) means u < Q.
    assign w_diff  = {1'b0, r_u3} - {2'b00, Q};
    assign w_res   = w_diff[13] ? r_u3[11:0] : w_diff[11:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_vld  <= {r_vld[LAT-1:0], en};
            // Registered form of "any stage valid": built from the next-state
            // of the valid bits so busy rises right after the first accept
            // and falls right after the last done.
            r_busy <= en | (|r_vld[LAT-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_t1  <= '0;
            r_t2  <= '0;
            r_m2  <= '0;
            r_u3  <= '0;
            r_res <= '0;
        end else begin
            if (en) begin
                r_a <= a;
                r_b <= b;
            end
            r_t1 <= w_prod;
            r_t2 <= r_t1;
            r_m2 <= w_m;
            r_u3 <= w_u;
            // Output holds its last value between results.
            if (r_vld[LAT-1]) begin
                r_res <= w_res;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_vld[LAT];
    assign r    = r_res;

endmodule

// File: tb/tb_montgomery_top.sv
// -----------------------------------------------------------------------------
// tb_montgomery_top
// Scoreboard bench for montgomery_top.  Stimulus pushes the expected result
// (a*b*R^-1 mod q computed with plain integer arithmetic) together with the
// cycle on which done must appear; an independent monitor pops and compares
// whenever done is seen, and also checks busy against the set of operations
// the scoreboard knows to be in flight.
// -----------------------------------------------------------------------------
module tb_montgomery_top;

    localparam int QM   = 3329;
    localparam int RINV = 2704;   // 2^-12 mod 3329

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] a;
    logic [11:0] b;
    logic        busy;
    logic        done;
    logic [11:0] r;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;
    bit   chk_busy = 1'b1;

    montgomery_top dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(input int av, input int bv);
        longint p;
        p = longint'(av) * longint'(bv) * longint'(RINV);
        return int'(p % QM);
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called #1 after a rising edge; the values are sampled on the next edge
    // and the result is due at the falling edge five counter ticks later.
    task automatic drive(input logic e, input int av, input int bv, input bit track);
        exp_t x;
        en = e;
        a  = av[11:0];
        b  = bv[11:0];
        if (e && track) begin
            x.val = model(av, bv);
            x.cyc = cyc + 5;
            sb.push_back(x);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit   busy_exp = 1'b0;
            automatic exp_t e;
            foreach (sb[i]) if (sb[i].cyc - 4 <= cyc) busy_exp = 1'b1;
            if (chk_busy) check("busy", int'(busy), int'(busy_exp));
            if (done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("r_value", int'(r), e.val);
                    check("done_cycle", cyc, e.cyc);
                    check("r_reduced", int'(r < 12'd3329), 1);
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("done_missing", 0, 1);
            end
        end
    end

    initial begin
        int pat[6];
        pat = '{1, 0, 1, 1, 0, 1};
        rst_n = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;

        // Reset hold
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_r", int'(r), 0);
        rst_n = 1'b1;
        idle(2);

        // Directed single operations
        drive(1'b1, 1, 1, 1'b1);          idle(6);
        drive(1'b1, 767, 1, 1'b1);        idle(6);
        drive(1'b1, 767, 767, 1'b1);      idle(6);
        drive(1'b1, 0, 1234, 1'b1);       idle(6);
        drive(1'b1, 3328, 3328, 1'b1);    idle(6);
        drive(1'b1, 3328, 1, 1'b1);       idle(6);

        // Back-to-back random stream
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, int'($urandom_range(3328)), int'($urandom_range(3328)), 1'b1);
        end
        idle(8);

        // Bubble pattern
        for (int i = 0; i < 6; i++) begin
            drive(pat[i] != 0, int'($urandom_range(3328)), int'($urandom_range(3328)), 1'b1);
        end
        idle(8);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        check("busy_idle", int'(busy), 0);

        // Mid-stream reset: in-flight operations must vanish
        chk_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, int'($urandom_range(3328)), int'($urandom_range(3328)), 1'b0);
        end
        drive(1'b0, 0, 0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_r", int'(r), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 0, 0, 1'b0);
            check("midrst_no_done", int'(done), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
